// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter slice.
package wb_pkg;

  localparam int WB_ADR_W = 22;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unanswered strobed cycles and flags expiry on the last one.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_expire,
  output logic o_pulse
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;
  logic            r_pulse;
  logic            w_expire;

  assign w_expire = i_en && (r_cnt == LAST);
  assign o_expire = w_expire;
  assign o_pulse  = r_pulse;

  // o_pulse is the registered expiry, so it lands in the first ABORT cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_expire;
      if (!i_en || w_expire) r_cnt <= '0;
      else                   r_cnt <= r_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter: round-robin grant, owner muxing, watchdog abort.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int TIMEOUT = 255
) (
  input  logic             in_clock,
  input  logic             in_reset_n,
  input  logic             in_m0_cyc,
  input  logic             in_m0_stb,
  input  logic             in_m0_we,
  input  logic [ADR_W-1:0] in_m0_adr,
  input  logic [3:0]       in_m0_sel,
  input  logic [31:0]      in_m0_wdat,
  output logic             out_m0_ack,
  output logic             out_m0_err,
  output logic [31:0]      out_m0_rdat,
  input  logic             in_m1_cyc,
  input  logic             in_m1_stb,
  input  logic             in_m1_we,
  input  logic [ADR_W-1:0] in_m1_adr,
  input  logic [3:0]       in_m1_sel,
  input  logic [31:0]      in_m1_wdat,
  output logic             out_m1_ack,
  output logic             out_m1_err,
  output logic [31:0]      out_m1_rdat,
  output logic             out_wb_cyc,
  output logic             out_wb_stb,
  output logic             out_wb_we,
  output logic [ADR_W-1:0] out_wb_adr,
  output logic [3:0]       out_wb_sel,
  output logic [31:0]      out_wb_wdat,
  input  logic             in_wb_ack,
  input  logic             in_wb_err,
  input  logic [31:0]      in_wb_rdat,
  output logic             out_owner,
  output logic             out_busy,
  output logic             out_timeout
);

  wb_state_t r_state, w_state_nxt;
  logic      r_owner, w_owner_nxt;
  logic      r_rr_last, w_rr_nxt;

  logic w_own_cyc, w_own_stb;
  logic w_wd_en, w_expire, w_to_pulse;

  assign w_own_cyc = r_owner ? in_m1_cyc : in_m0_cyc;
  assign w_own_stb = r_owner ? in_m1_stb : in_m0_stb;
  assign w_wd_en   = (r_state == ST_OWN) && w_own_stb && !in_wb_ack && !in_wb_err;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clk    (in_clock),
    .i_rst_n  (in_reset_n),
    .i_en     (w_wd_en),
    .o_expire (w_expire),
    .o_pulse  (w_to_pulse)
  );

  // rr_last resets to 1 so that a simultaneous first request goes to m0.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_last;
    case (r_state)
      ST_IDLE: begin
        if (in_m0_cyc || in_m1_cyc) begin
          w_state_nxt = ST_OWN;
          if (in_m0_cyc && in_m1_cyc) w_owner_nxt = ~r_rr_last;
          else                        w_owner_nxt = in_m1_cyc;
        end
      end
      ST_OWN: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = r_owner;
        end else if (w_expire) begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = r_owner;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_wb_cyc  = 1'b0;
    out_wb_stb  = 1'b0;
    out_wb_we   = 1'b0;
    out_wb_adr  = '0;
    out_wb_sel  = '0;
    out_wb_wdat = '0;
    out_m0_ack  = 1'b0;
    out_m0_err  = 1'b0;
    out_m0_rdat = '0;
    out_m1_ack  = 1'b0;
    out_m1_err  = 1'b0;
    out_m1_rdat = '0;
    if (r_state == ST_OWN) begin
      out_wb_cyc  = w_own_cyc;
      out_wb_stb  = w_own_stb;
      out_wb_we   = r_owner ? in_m1_we   : in_m0_we;
      out_wb_adr  = r_owner ? in_m1_adr  : in_m0_adr;
      out_wb_sel  = r_owner ? in_m1_sel  : in_m0_sel;
      out_wb_wdat = r_owner ? in_m1_wdat : in_m0_wdat;
      out_m0_ack  = !r_owner && in_wb_ack;
      out_m0_err  = !r_owner && in_wb_err;
      out_m1_ack  = r_owner && in_wb_ack;
      out_m1_err  = r_owner && in_wb_err;
      out_m0_rdat = in_wb_rdat;
      out_m1_rdat = in_wb_rdat;
    end else if (r_state == ST_ABORT) begin
      out_m0_err = !r_owner && w_to_pulse;
      out_m1_err = r_owner && w_to_pulse;
    end
  end

  assign out_busy    = (r_state != ST_IDLE);
  assign out_owner   = out_busy && r_owner;
  assign out_timeout = (r_state == ST_ABORT) && w_to_pulse;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with TIMEOUT=8.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [21:0] m0_adr = '0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_wdat = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [21:0] m1_adr = '0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_wdat = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [21:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdat;
  logic        wb_ack = 0, wb_err = 0;
  logic [31:0] wb_rdat = '0;
  logic        owner, busy, tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADR_W(22), .TIMEOUT(8)) dut (
    .in_clock(clk), .in_reset_n(rst_n),
    .in_m0_cyc(m0_cyc), .in_m0_stb(m0_stb), .in_m0_we(m0_we), .in_m0_adr(m0_adr),
    .in_m0_sel(m0_sel), .in_m0_wdat(m0_wdat),
    .out_m0_ack(m0_ack), .out_m0_err(m0_err), .out_m0_rdat(m0_rdat),
    .in_m1_cyc(m1_cyc), .in_m1_stb(m1_stb), .in_m1_we(m1_we), .in_m1_adr(m1_adr),
    .in_m1_sel(m1_sel), .in_m1_wdat(m1_wdat),
    .out_m1_ack(m1_ack), .out_m1_err(m1_err), .out_m1_rdat(m1_rdat),
    .out_wb_cyc(wb_cyc), .out_wb_stb(wb_stb), .out_wb_we(wb_we), .out_wb_adr(wb_adr),
    .out_wb_sel(wb_sel), .out_wb_wdat(wb_wdat),
    .in_wb_ack(wb_ack), .in_wb_err(wb_err), .in_wb_rdat(wb_rdat),
    .out_owner(owner), .out_busy(busy), .out_timeout(tmo)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    chk("rst_tmo_owner", {30'd0, tmo, owner}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: m0 read with ack two cycles after stb
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 22'h000010; m0_sel = 4'hF;
    #1 chk("t1_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    tick();
    chk("t1_wb_cyc", {31'd0, wb_cyc}, 32'd1);
    chk("t1_adr", {10'd0, wb_adr}, 32'h000010);
    chk("t1_busy_owner", {30'd0, busy, owner}, 32'b10);
    tick();
    tick();
    wb_ack = 1; wb_rdat = 32'hDEADBEEF;
    #1 chk("t1_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("t1_m0_rdat", m0_rdat, 32'hDEADBEEF);
    chk("t1_m1_ack", {31'd0, m1_ack}, 32'd0);
    tick();
    wb_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 chk("t1_busy_hold", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_drop", {31'd0, busy}, 32'd0);

    // 2: simultaneous request from reset, then alternating grants
    rst_n = 0;
    #1 rst_n = 1;
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("t2_grant0", {30'd0, busy, owner}, 32'b10);
    m0_cyc = 0;
    tick();
    chk("t2_idle_gap", {31'd0, busy}, 32'd0);
    m0_cyc = 1;
    tick();
    chk("t2_grant1", {30'd0, busy, owner}, 32'b11);
    wb_ack = 1;
    #1 chk("t2_holdoff", {30'd0, m0_ack, m1_ack}, 32'b01);
    wb_ack = 0; m1_cyc = 0;
    tick();
    m1_cyc = 1;
    tick();
    chk("t2_grant0b", {30'd0, busy, owner}, 32'b10);
    m0_cyc = 0;
    tick();
    m0_cyc = 1;
    tick();
    chk("t2_grant1b", {30'd0, busy, owner}, 32'b11);
    m0_cyc = 0; m1_cyc = 0;
    tick();
    tick();

    // 3: m1 write at max address
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011; m1_wdat = 32'h1234ABCD;
    m1_adr = 22'h3FFFFF;
    tick();
    chk("t3_we_stb", {30'd0, wb_we, wb_stb}, 32'b11);
    chk("t3_sel", {28'd0, wb_sel}, 32'h3);
    chk("t3_adr", {10'd0, wb_adr}, 32'h3FFFFF);
    chk("t3_wdat", wb_wdat, 32'h1234ABCD);
    wb_ack = 1;
    #1 chk("t3_ack", {30'd0, m0_ack, m1_ack}, 32'b01);
    tick();
    wb_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    tick();

    // 4: slave never responds, abort after TIMEOUT
    m0_cyc = 1; m0_stb = 1; m0_we = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t4_wait%0d", i), {29'd0, wb_cyc, m0_err, tmo}, 32'b100);
    end
    tick();
    chk("t4_abort_pulse", {30'd0, m0_err, tmo}, 32'b11);
    chk("t4_abort_bus", {29'd0, wb_cyc, wb_stb, busy}, 32'b001);
    wb_ack = 1;
    #1 chk("t4_late_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    chk("t4_pulse_end", {29'd0, m0_err, tmo, wb_cyc}, 32'd0);
    wb_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t4_release", {31'd0, busy}, 32'd0);

    // 5: ack on the last permitted cycle
    m0_cyc = 1; m0_stb = 1;
    for (int i = 1; i <= 8; i++) tick();
    wb_ack = 1; wb_rdat = 32'hCAFEF00D;
    #1 chk("t5_ack", {30'd0, m0_ack, tmo}, 32'b10);
    chk("t5_rdat", m0_rdat, 32'hCAFEF00D);
    tick();
    chk("t5_no_abort", {29'd0, busy, m0_err, tmo}, 32'b100);
    wb_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    tick();

    // 6: asynchronous reset mid-write while m1 owns the bus
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    tick();
    wb_ack = 1;
    #1 chk("t6_pre", {29'd0, busy, owner, m1_ack}, 32'b111);
    rst_n = 0;
    #1 chk("t6_async", {26'd0, wb_cyc, wb_stb, busy, owner, m1_ack, m0_ack}, 32'd0);
    chk("t6_err_tmo", {29'd0, m0_err, m1_err, tmo}, 32'd0);
    wb_ack = 0; m0_cyc = 1;
    tick();
    rst_n = 1;
    tick();
    chk("t6_m0_wins", {30'd0, busy, owner}, 32'b10);
    m0_cyc = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone classic arbiter with round-robin grant and a bus-timeout watchdog.
- Master 0 is the picobus-to-Wishbone bridge. Master 1 is a second requester, such as a DMA or debug master.
- The slave side drives the shared 22-bit word-addressed peripheral bus.
- A stalled slave is aborted with an error to its owner instead of hanging the CPU.

Parameters:
- ADR_W, 22, Wishbone word-address width.
- TIMEOUT, 255, cycles a strobed transfer may wait for ack/err before abort. Legal range is 1..65535.
- TO_W, $clog2(TIMEOUT+1), watchdog counter width. Derived; do not override.

Ports:
- in_clock  in  1  system clock
- in_reset_n  in  1  reset, asynchronous, active-low
- in_m0_cyc, in_m0_stb, in_m0_we  in  1 each  master 0 request
- in_m0_adr  in  ADR_W  master 0 address
- in_m0_sel  in  4  master 0 byte select
- in_m0_wdat  in  32  master 0 write data
- out_m0_ack, out_m0_err  out  1 each  master 0 response
- out_m0_rdat  out  32  master 0 read data
- in_m1_* / out_m1_*  same set for master 1
- out_wb_cyc, out_wb_stb, out_wb_we  out  1 each  slave request
- out_wb_adr  out  ADR_W  slave address
- out_wb_sel  out  4  slave byte select
- out_wb_wdat  out  32  slave write data
- in_wb_ack, in_wb_err  in  1 each  slave response
- in_wb_rdat  in  32  slave read data
- out_owner  out  1  current owner index; valid when out_busy=1
- out_busy  out  1  a master holds the bus
- out_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: one clock (in_clock); reset is asynchronous, active-low (in_reset_n). On assertion, immediately and mid-transfer:
  - state=IDLE, round-robin pointer prefers m0, watchdog=0.
  - All outputs are 0, including out_wb_cyc/stb, every ack/err, out_timeout, out_busy and out_owner.
  - rdat outputs may be 0.
- States: IDLE, OWN, ABORT. Registers: state, owner, rr_last, watchdog counter.
- IDLE:
  - Only m0 cyc=1: owner=0, go to OWN on the next edge.
  - Only m1 cyc=1: owner=1, go to OWN on the next edge.
  - Both cyc=1: grant the master not equal to rr_last.
  - Arbitration latency is 1 cycle; no slave signal is driven in IDLE.
- OWN:
  - out_wb_cyc = owner cyc; out_wb_stb = owner stb.
  - we/adr/sel/wdat are combinationally muxed from the owner.
  - in_wb_ack/err are routed combinationally to the owner's ack/err only. The non-owner ack/err stay 0.
  - in_wb_rdat is routed to both masters' rdat; only the owner's ack qualifies it.
  - Release: when owner cyc=0, set rr_last=owner and go to IDLE. There is one idle cycle between tenures.
  - Owner stb=0 with cyc=1 holds the bus (locked multi-beat cycle).
- Watchdog:
  - Counts cycles in OWN with out_wb_stb=1 and in_wb_ack=0 and in_wb_err=0.
  - Clears on ack, err, stb=0 or leaving OWN.
  - When count==TIMEOUT-1 and still no response:
    - Next cycle enters ABORT.
    - In that same edge's following cycle, out_<owner>_err=1 for exactly one cycle and out_timeout=1.
    - out_wb_cyc/stb = 0 throughout ABORT.
- ABORT:
  - Slave responses are ignored and not forwarded.
  - When owner cyc=0: set rr_last=owner and go to IDLE.
- Simultaneous ack and err from the slave: forward both. The master resolves them; the picobus bridge treats ack as priority.
- A late slave ack/err arriving after abort, or in IDLE, is dropped.
- Requests from the non-owner during OWN/ABORT are held off; that master sees no response.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1.

Decomposition:
- Shared package wb_pkg holds:
  - the state encoding localparams (IDLE=0, OWN=1, ABORT=2);
  - WB_ADR_W=22;
  - the Wishbone data width 32.
- One sub-module is natural: wb_watchdog, containing the counter, clear/enable and expire pulse, parameterised by TIMEOUT.
- The grant logic and muxes stay in wb_arbiter_2m.

Test Plan:
1. m0 reads adr 0x000010, slave acks 2 cycles after stb with rdat 0xDEADBEEF.
   - Required: out_wb_cyc rises 1 cycle after in_m0_cyc; out_m0_ack=1 with out_m0_rdat=0xDEADBEEF; out_m1_ack stays 0.
   - Required: out_busy drops 1 cycle after m0 cyc drops.
2. m0 and m1 both raise cyc in the same cycle from reset.
   - Required: m0 is granted first; after m0 releases, m1 is granted after 1 idle cycle.
   - Continuous requests then give grants in the order 0,1,0,1.
3. m1 writes sel=4'b0011, wdat=0x1234ABCD, adr 0x3FFFFF (max).
   - Required: out_wb_we=1, sel=0011, adr=0x3FFFFF and wdat are passed unchanged.
4. TIMEOUT=8, slave never responds to m0.
   - Required: out_m0_err and out_timeout each pulse 1 cycle, 9 cycles after stb rises.
   - Required: out_wb_cyc=0 in ABORT.
   - Required: a late in_wb_ack is not seen on out_m0_ack.
5. Slave returns ack on the cycle count reaches TIMEOUT-1.
   - Required: normal ack, no abort, out_timeout stays 0.
6. in_reset_n pulled low mid-write while m1 owns the bus.
   - Required: out_wb_cyc/stb, out_busy and all ack/err go 0 without a clock edge.
   - Required: after release, m0 wins a simultaneous request.
